// File: rtl/menu_sel_ctl_if.sv
// Video timing/pixel stream, mouse sampling and selection-event bundle for menu_sel_ctl.
// MENU_KBD_EN adds the key_up/key_down/key_enter pulse inputs.
interface menu_sel_ctl_if #(
  parameter int unsigned IDX_W = 2
);
  logic             menu_en;
  logic [10:0]      hcount_in;
  logic [10:0]      vcount_in;
  logic             hsync_in;
  logic             vsync_in;
  logic             hblnk_in;
  logic             vblnk_in;
  logic [11:0]      rgb_in;
  logic [11:0]      xpos;
  logic [11:0]      ypos;
  logic             mouse_left;
`ifdef MENU_KBD_EN
  logic             key_up;
  logic             key_down;
  logic             key_enter;
`endif
  logic [10:0]      hcount_out;
  logic [10:0]      vcount_out;
  logic             hsync_out;
  logic             vsync_out;
  logic             hblnk_out;
  logic             vblnk_out;
  logic [11:0]      rgb_out;
  logic             hover_valid;
  logic [IDX_W-1:0] hover_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;

  modport slave (
    input  menu_en, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, mouse_left,
`ifdef MENU_KBD_EN
    input  key_up, key_down, key_enter,
`endif
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, hover_valid, hover_idx, sel_valid, sel_idx
  );

  modport master (
    output menu_en, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, mouse_left,
`ifdef MENU_KBD_EN
    output key_up, key_down, key_enter,
`endif
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, hover_valid, hover_idx, sel_valid, sel_idx
  );
endinterface

// File: rtl/menu_sel_ctl.sv
// Clickable N_ITEMS-button menu overlay with 2-clk video pipeline and press/release selection FSM.
// Optional keyboard cursor/enter control is enabled by defining MENU_KBD_EN.
module menu_sel_ctl #(
  parameter int unsigned N_ITEMS    = 3,
  parameter int unsigned ITEM_X     = 312,
  parameter int unsigned ITEM_Y0    = 200,
  parameter int unsigned ITEM_W     = 176,
  parameter int unsigned ITEM_H     = 48,
  parameter int unsigned ITEM_GAP   = 16,
  parameter logic [11:0] COL_ITEM   = 12'h444,
  parameter logic [11:0] COL_HOVER  = 12'h888,
  parameter logic [11:0] COL_SEL    = 12'h0F0,
  parameter logic [11:0] COL_BORDER = 12'hFFF
) (
  input logic          clk,
  input logic          rst,
  menu_sel_ctl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_ITEMS);
  localparam logic [11:0] X0  = 12'(ITEM_X);
  localparam logic [11:0] X1  = 12'(ITEM_X + ITEM_W);
  localparam logic [11:0] H12 = 12'(ITEM_H);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLD} state_t;

  function automatic logic [11:0] f_top(input int unsigned i);
    return 12'(ITEM_Y0 + i * (ITEM_H + ITEM_GAP));
  endfunction

  // Stage 1 video registers
  logic [10:0]      r_hc1, r_vc1;
  logic             r_hs1, r_vs1, r_hb1, r_vb1, r_en1;
  logic [11:0]      r_rgb1;
  logic             r_in1, r_bord1;
  logic [IDX_W-1:0] r_idx1;
  // Stage 2 video registers
  logic [10:0]      r_hc2, r_vc2;
  logic             r_hs2, r_vs2, r_hb2, r_vb2;
  logic [11:0]      r_rgb2;
  // Selection state
  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_arm_idx, w_arm_nx;
  logic [IDX_W-1:0] r_cursor, r_sel_idx, r_hov_idx;
  logic             r_sel_valid, r_hov_valid;

  logic [11:0]      w_px, w_py;
  logic             w_pix_in, w_pix_bord;
  logic [IDX_W-1:0] w_pix_idx;
  logic             w_ms_in;
  logic [IDX_W-1:0] w_ms_idx;
  logic             w_samp, w_msel, w_ksel;
  logic [11:0]      w_rgb;

  assign w_px   = {1'b0, bus.hcount_in};
  assign w_py   = {1'b0, bus.vcount_in};
  assign w_samp = bus.vblnk_in & ~r_vb1;

  always_comb begin
    w_pix_in   = 1'b0;
    w_pix_idx  = '0;
    w_pix_bord = 1'b0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (w_px >= X0 && w_px < X1 && w_py >= f_top(i) && w_py < f_top(i) + H12) begin
        w_pix_in   = 1'b1;
        w_pix_idx  = IDX_W'(i);
        w_pix_bord = (w_px < X0 + 12'd2) || (w_px >= X1 - 12'd2) ||
                     (w_py < f_top(i) + 12'd2) || (w_py >= f_top(i) + H12 - 12'd2);
      end
    end
  end

  always_comb begin
    w_ms_in  = 1'b0;
    w_ms_idx = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (bus.xpos >= X0 && bus.xpos < X1 && bus.ypos >= f_top(i) && bus.ypos < f_top(i) + H12) begin
        w_ms_in  = 1'b1;
        w_ms_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_rgb = r_rgb1;
    if (r_en1) begin
      if (r_hb1 || r_vb1)                          w_rgb = '0;
      else if (r_in1) begin
        if (r_bord1)                               w_rgb = COL_BORDER;
        else if (r_idx1 == r_cursor)               w_rgb = COL_SEL;
        else if (r_hov_valid && r_hov_idx == r_idx1) w_rgb = COL_HOVER;
        else                                       w_rgb = COL_ITEM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc1 <= '0; r_vc1 <= '0; r_hs1 <= 1'b0; r_vs1 <= 1'b0; r_hb1 <= 1'b0; r_vb1 <= 1'b0;
      r_en1 <= 1'b0; r_rgb1 <= '0; r_in1 <= 1'b0; r_bord1 <= 1'b0; r_idx1 <= '0;
      r_hc2 <= '0; r_vc2 <= '0; r_hs2 <= 1'b0; r_vs2 <= 1'b0; r_hb2 <= 1'b0; r_vb2 <= 1'b0;
      r_rgb2 <= '0;
    end else begin
      r_hc1 <= bus.hcount_in; r_vc1 <= bus.vcount_in;
      r_hs1 <= bus.hsync_in;  r_vs1 <= bus.vsync_in;
      r_hb1 <= bus.hblnk_in;  r_vb1 <= bus.vblnk_in;
      r_en1 <= bus.menu_en;   r_rgb1 <= bus.rgb_in;
      r_in1 <= w_pix_in;      r_bord1 <= w_pix_bord; r_idx1 <= w_pix_idx;
      r_hc2 <= r_hc1; r_vc2 <= r_vc1; r_hs2 <= r_hs1; r_vs2 <= r_vs1;
      r_hb2 <= r_hb1; r_vb2 <= r_vb1; r_rgb2 <= w_rgb;
    end
  end

  // Mouse-driven FSM only advances on the vblank-rise clock, using that clock's mouse sample.
  always_comb begin
    w_state_nx = r_state;
    w_arm_nx   = r_arm_idx;
    w_msel     = 1'b0;
    if (!bus.menu_en) begin
      w_state_nx = S_IDLE;
    end else if (w_samp) begin
      case (r_state)
        S_IDLE: if (bus.mouse_left) begin
          if (w_ms_in) begin
            w_state_nx = S_ARMED;
            w_arm_nx   = w_ms_idx;
          end else begin
            w_state_nx = S_HOLD;
          end
        end
        S_ARMED: if (!bus.mouse_left) begin
          w_state_nx = S_IDLE;
          w_msel     = w_ms_in && (w_ms_idx == r_arm_idx);
        end
        S_HOLD: if (!bus.mouse_left) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_arm_idx <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_arm_idx <= w_arm_nx;
    end
  end

`ifdef MENU_KBD_EN
  assign w_ksel = bus.menu_en & bus.key_enter & ~w_msel;
`else
  assign w_ksel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_valid <= 1'b0;
      r_sel_idx   <= '0;
      r_cursor    <= '0;
      r_hov_valid <= 1'b0;
      r_hov_idx   <= '0;
    end else begin
      r_sel_valid <= w_msel | w_ksel;
      if (w_samp) begin
        r_hov_valid <= w_ms_in;
        r_hov_idx   <= w_ms_idx;
      end
      if (w_msel) begin
        r_sel_idx <= r_arm_idx;
        r_cursor  <= r_arm_idx;
      end else begin
        if (w_ksel) r_sel_idx <= r_cursor;
`ifdef MENU_KBD_EN
        if (bus.menu_en && (bus.key_up ^ bus.key_down)) begin
          if (bus.key_up)
            r_cursor <= (r_cursor == '0) ? IDX_W'(N_ITEMS - 1) : r_cursor - 1'b1;
          else
            r_cursor <= (r_cursor == IDX_W'(N_ITEMS - 1)) ? '0 : r_cursor + 1'b1;
        end
`endif
      end
    end
  end

  assign bus.hcount_out  = r_hc2;
  assign bus.vcount_out  = r_vc2;
  assign bus.hsync_out   = r_hs2;
  assign bus.vsync_out   = r_vs2;
  assign bus.hblnk_out   = r_hb2;
  assign bus.vblnk_out   = r_vb2;
  assign bus.rgb_out     = r_rgb2;
  assign bus.hover_valid = r_hov_valid;
  assign bus.hover_idx   = r_hov_idx;
  assign bus.sel_valid   = r_sel_valid;
  assign bus.sel_idx     = r_sel_idx;
endmodule
